// File: rtl/thread_id_table.sv
// thread_id_table: flop ID table with NUM_WR write ports, per-entry valid and base+i*stride fill sequencer.
// Optional THREAD_ID_CLEAR_EN adds clr, which invalidates all entries and aborts a fill.
module thread_id_table #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ADDR_DEPTH = 1 << ADDR_WIDTH,
  parameter int NUM_WR = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef THREAD_ID_CLEAR_EN
  input  logic clr,
`endif
  input  logic [NUM_WR-1:0] we,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wa,
  input  logic [NUM_WR*DATA_WIDTH-1:0] di,
  input  logic fill_start,
  input  logic [DATA_WIDTH-1:0] fill_base,
  input  logic [DATA_WIDTH-1:0] fill_stride,
  input  logic [ADDR_WIDTH:0] fill_count,
  output logic fill_busy,
  output logic fill_done,
  output logic [DATA_WIDTH-1:0] dout [ADDR_DEPTH],
  output logic [ADDR_DEPTH-1:0] valid
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  localparam logic [ADDR_WIDTH:0] DEPTH_N = (ADDR_WIDTH+1)'(ADDR_DEPTH);
  state_t state, next;
  logic wipe, last;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH:0] cnt, n_sat;
  logic [DATA_WIDTH-1:0] acc, stride;
`ifdef THREAD_ID_CLEAR_EN
  assign wipe = clr;
`else
  assign wipe = 1'b0;
`endif
  assign n_sat = fill_count > DEPTH_N ? DEPTH_N : fill_count;
  assign last = {1'b0, idx} == cnt - 1'b1;
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb
    next = wipe ? IDLE
         : state == IDLE ? (fill_start ? (n_sat == '0 ? DONE : FILL) : IDLE)
         : state == FILL ? (last ? DONE : FILL)
         : IDLE;
  always_comb begin
    fill_busy = state == FILL;
    fill_done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      cnt <= '0;
      acc <= '0;
      stride <= '0;
      valid <= '0;
      for (int i = 0; i < ADDR_DEPTH; i++) dout[i] <= '0;
    end else begin
      if (state == IDLE && fill_start) begin
        acc <= fill_base;
        stride <= fill_stride;
        cnt <= n_sat;
        idx <= '0;
      end else if (state == FILL) begin
        acc <= acc + stride;
        idx <= idx + 1'b1;
      end
      if (wipe) valid <= '0;
      else begin
        for (int p = 0; p < NUM_WR; p++)
          if (we[p]) begin
            dout[wa[p*ADDR_WIDTH +: ADDR_WIDTH]] <= di[p*DATA_WIDTH +: DATA_WIDTH];
            valid[wa[p*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b1;
          end
        if (state == FILL) begin
          dout[idx] <= acc;
          valid[idx] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_thread_id_table.sv
// tb_thread_id_table: vector table for port writes plus fill sequences checked against a reference model.
module tb_thread_id_table;
  logic clk = 0, rst = 1, clr = 0, fill_start = 0, fill_busy, fill_done;
  logic [1:0] we = '0;
  logic [9:0] wa = '0;
  logic [63:0] di = '0;
  logic [31:0] fill_base = '0, fill_stride = '0;
  logic [5:0] fill_count = '0;
  logic [31:0] dout [32];
  logic [31:0] valid;
  logic [31:0] m_d [32];
  logic [31:0] m_v;
  int checks = 0, errors = 0;
  typedef struct {
    logic [1:0] we;
    logic [4:0] a0, a1;
    logic [31:0] d0, d1;
    int ca;
    logic [31:0] cd;
    logic cv;
  } vec_t;
  typedef struct {
    int a;
    logic [31:0] d;
    logic v;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[6];
  always #5 clk = ~clk;
  thread_id_table dut (
    .clk(clk), .rst(rst),
`ifdef THREAD_ID_CLEAR_EN
    .clr(clr),
`endif
    .we(we), .wa(wa), .di(di), .fill_start(fill_start), .fill_base(fill_base),
    .fill_stride(fill_stride), .fill_count(fill_count), .fill_busy(fill_busy),
    .fill_done(fill_done), .dout(dout), .valid(valid)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic model_reset;
    for (int i = 0; i < 32; i++) m_d[i] = '0;
    m_v = '0;
  endtask
  task automatic cmp_model(string nm);
    int bad = -1;
    for (int i = 0; i < 32; i++)
      if (bad < 0 && (dout[i] !== m_d[i] || valid[i] !== m_v[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: entry %0d dout=%h valid=%b, want dout=%h valid=%b",
               nm, bad, dout[bad], valid[bad], m_d[bad], m_v[bad]);
    end
  endtask
  // mode 0 plain, 1 collision + ignored restart, 2 rst at 3rd fill cycle, 3 clr at 3rd fill cycle
  task automatic run_fill(string nm, logic [31:0] base, logic [31:0] str, logic [5:0] cnt, int mode);
    int n;
    logic [31:0] acc;
    exp_t e;
    n = cnt > 32 ? 32 : int'(cnt);
    acc = base;
    fill_base = base;
    fill_stride = str;
    fill_count = cnt;
    fill_start = 1;
    for (int i = 0; i < n; i++) sb.push_back('{i, base + str * i, 1'b1});
    step;
    fill_start = 0;
    chk({nm, " busy@T+1"}, fill_busy, n > 0);
    chk({nm, " done@T+1"}, fill_done, n == 0);
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && i == 1) begin
        fill_start = 1;
        fill_base = 32'h7777;
        fill_count = 6'd3;
      end
      if (mode == 1 && i == 2) begin
        we = 2'b01;
        wa[4:0] = 5'd2;
        di[31:0] = 32'h0BAD;
        m_d[2] = 32'h0BAD;
        m_v[2] = 1'b1;
      end
      if (mode >= 2 && i == 2) begin
        if (mode == 2) rst = 1;
        else clr = 1;
        we = 2'b10;
        wa[9:5] = 5'd20;
        di[63:32] = 32'd1234;
      end
      step;
      fill_start = 0;
      rst = 0;
      clr = 0;
      we = '0;
      if (mode >= 2 && i == 2) begin
        if (mode == 2) model_reset();
        else m_v = '0;
        chk({nm, " busy after abort"}, fill_busy, 0);
        chk({nm, " done after abort"}, fill_done, 0);
        cmp_model({nm, " table after abort"});
        repeat (3) begin
          step;
          chk({nm, " no late done"}, fill_done, 0);
          chk({nm, " no late busy"}, fill_busy, 0);
        end
        sb.delete();
        return;
      end
      m_d[i] = acc;
      m_v[i] = 1'b1;
      acc += str;
      chk($sformatf("%s busy i=%0d", nm, i), fill_busy, i < n - 1);
      chk($sformatf("%s done i=%0d", nm, i), fill_done, i == n - 1);
    end
    step;
    chk({nm, " done cleared"}, fill_done, 0);
    chk({nm, " busy idle"}, fill_busy, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("%s entry %0d", nm, e.a), {dout[e.a], valid[e.a]}, {e.d, e.v});
    end
    cmp_model({nm, " table"});
  endtask
  initial begin
    exp_t e;
    tbl[0] = '{2'b01, 5'd3, 5'd0, 32'hAA, 32'h0, 3, 32'hAA, 1'b1};
    tbl[1] = '{2'b11, 5'd3, 5'd3, 32'hAA, 32'hBB, 3, 32'hBB, 1'b1};
    tbl[2] = '{2'b10, 5'd0, 5'd5, 32'h0, 32'h55, 5, 32'h55, 1'b1};
    tbl[3] = '{2'b01, 5'd31, 5'd0, 32'hDEAD, 32'h0, 31, 32'hDEAD, 1'b1};
    tbl[4] = '{2'b11, 5'd0, 5'd1, 32'h11, 32'h22, 1, 32'h22, 1'b1};
    tbl[5] = '{2'b00, 5'd2, 5'd2, 32'hFF, 32'hEE, 2, 32'h0, 1'b0};
    model_reset();
    step;
    step;
    rst = 0;
    repeat (3) step;
    chk("reset busy", fill_busy, 0);
    chk("reset done", fill_done, 0);
    chk("reset valid", valid, 0);
    cmp_model("reset table");
    for (int k = 0; k < 6; k++) begin
      we = tbl[k].we;
      wa = {tbl[k].a1, tbl[k].a0};
      di = {tbl[k].d1, tbl[k].d0};
      if (tbl[k].we[0]) begin m_d[tbl[k].a0] = tbl[k].d0; m_v[tbl[k].a0] = 1'b1; end
      if (tbl[k].we[1]) begin m_d[tbl[k].a1] = tbl[k].d1; m_v[tbl[k].a1] = 1'b1; end
      sb.push_back('{tbl[k].ca, tbl[k].cd, tbl[k].cv});
      step;
      we = '0;
      e = sb.pop_front();
      chk($sformatf("vec%0d dout", k), dout[e.a], e.d);
      chk($sformatf("vec%0d valid", k), valid[e.a], e.v);
      cmp_model($sformatf("vec%0d table", k));
    end
    chk("vec valid[2] unset", valid[2], 0);
    rst = 1;
    step;
    rst = 0;
    model_reset();
    run_fill("fill100", 32'd100, 32'd4, 6'd8, 0);
    chk("fill100 valid[8..31]", valid[31:8], 0);
    run_fill("wrap", 32'hFFFF_FFFE, 32'd1, 6'd4, 0);
    run_fill("count0", 32'd55, 32'd1, 6'd0, 0);
    run_fill("count40", 32'd7, 32'd3, 6'd40, 0);
    run_fill("collide", 32'd1000, 32'd10, 6'd6, 1);
    run_fill("rstmid", 32'd5, 32'd5, 6'd10, 2);
`ifdef THREAD_ID_CLEAR_EN
    run_fill("fill_pre_clr", 32'd3, 32'd2, 6'd4, 0);
    run_fill("clrmid", 32'd9, 32'd1, 6'd10, 3);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
